// File: rtl/sparse_pe_pkg.sv
// Shared types and default sizing for the sparse partial-sum reducer.
package sparse_pe_pkg;

  localparam int LANES_DEF     = 3;
  localparam int W_BITS_DEF    = 16;
  localparam int IA_BITS_DEF   = 16;
  localparam int ADDR_DIMS_DEF = 3;
  localparam int ADDR_BITS_DEF = 7;
  localparam int ACC_BITS_DEF  = 34;
  localparam int DEPTH_DEF     = 48;
  localparam int IDX_BITS_DEF  = $clog2(DEPTH_DEF);
  localparam int CNT_BITS_DEF  = $clog2(DEPTH_DEF + 1);

  typedef logic [ADDR_DIMS_DEF-1:0][ADDR_BITS_DEF-1:0] addr_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/psum_run_merger.sv
// Multiplies each lane pair, flags equal-address neighbours, and folds each run
// of equal addresses into one sum. Two register stages, no buffer state.
module psum_run_merger
  import sparse_pe_pkg::*;
#(
  parameter int LANES     = LANES_DEF,
  parameter int W_BITS    = W_BITS_DEF,
  parameter int IA_BITS   = IA_BITS_DEF,
  parameter int ADDR_DIMS = ADDR_DIMS_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int SUM_BITS  = W_BITS_DEF + IA_BITS_DEF + $clog2(LANES_DEF)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   valid_i,
  input  logic                                   last_i,
  input  logic [LANES*W_BITS-1:0]                w_i,
  input  logic [LANES*IA_BITS-1:0]               ia_i,
  input  logic [LANES*ADDR_DIMS*ADDR_BITS-1:0]   addr_i,
  input  logic                                   first_i,
  input  logic [ADDR_DIMS*ADDR_BITS-1:0]         last_addr_i,
  output logic                                   valid_o,
  output logic                                   last_o,
  output logic [LANES-1:0][SUM_BITS-1:0]         run_sum_o,
  output logic [$clog2(LANES+1)-1:0]             run_cnt_o,
  output logic                                   same0_o
);

  localparam int AW   = ADDR_DIMS * ADDR_BITS;
  localparam int PW   = W_BITS + IA_BITS;
  localparam int RC_W = $clog2(LANES + 1);
  localparam int RI_W = $clog2(LANES);

  logic [LANES-1:0][PW-1:0]       prod_d, prod_q;
  logic [LANES-1:0]               same_d, same_q;
  logic                           p1_valid_q, p1_last_q;
  logic [LANES-1:0][RI_W-1:0]     run_idx;
  logic [LANES-1:0][SUM_BITS-1:0] sum_d, sum_q;
  logic [RC_W-1:0]                cnt_d, cnt_q;
  logic                           p2_valid_q, p2_last_q, p2_same0_q;

  always_comb begin
    prod_d = '0;
    same_d = '0;
    for (int k = 0; k < LANES; k++) begin
      prod_d[k] = {{IA_BITS{1'b0}}, w_i[k*W_BITS +: W_BITS]} *
                  {{W_BITS{1'b0}}, ia_i[k*IA_BITS +: IA_BITS]};
    end
    same_d[0] = !first_i && (addr_i[AW-1:0] == last_addr_i);
    for (int k = 1; k < LANES; k++) begin
      same_d[k] = (addr_i[k*AW +: AW] == addr_i[(k-1)*AW +: AW]);
    end
  end

  // Lane 0 always lands in run 0; every later address change opens the next run.
  always_comb begin
    run_idx = '0;
    sum_d   = '0;
    cnt_d   = RC_W'(!same_q[0]);
    for (int k = 1; k < LANES; k++) begin
      run_idx[k] = run_idx[k-1] + RI_W'(!same_q[k]);
      cnt_d      = cnt_d + RC_W'(!same_q[k]);
    end
    for (int r = 0; r < LANES; r++) begin
      for (int k = 0; k < LANES; k++) begin
        if (run_idx[k] == RI_W'(r)) sum_d[r] = sum_d[r] + SUM_BITS'(prod_q[k]);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p1_valid_q <= 1'b0;
      p1_last_q  <= 1'b0;
      p2_valid_q <= 1'b0;
      p2_last_q  <= 1'b0;
    end else begin
      p1_valid_q <= valid_i;
      p1_last_q  <= valid_i && last_i;
      p2_valid_q <= p1_valid_q;
      p2_last_q  <= p1_valid_q && p1_last_q;
    end
  end

  always_ff @(posedge clk_i) begin
    prod_q     <= prod_d;
    same_q     <= same_d;
    sum_q      <= sum_d;
    cnt_q      <= cnt_d;
    p2_same0_q <= same_q[0];
  end

  assign valid_o   = p2_valid_q;
  assign last_o    = p2_last_q;
  assign run_sum_o = sum_q;
  assign run_cnt_o = cnt_q;
  assign same0_o   = p2_same0_q;

endmodule

// File: rtl/sparse_psum_reducer.sv
// Accumulates address-merged product runs into a DEPTH-entry partial-sum buffer
// with cross-beat merging, overflow tracking and a registered readback port.
//   state   | meaning
//   S_IDLE  | waiting for i_start; readback allowed
//   S_RUN   | accepting beats (o_ready=1)
//   S_FLUSH | last beat accepted, draining the pipe
//   S_DONE  | one-cycle o_done pulse
module sparse_psum_reducer
  import sparse_pe_pkg::*;
#(
  parameter int LANES     = LANES_DEF,
  parameter int W_BITS    = W_BITS_DEF,
  parameter int IA_BITS   = IA_BITS_DEF,
  parameter int ADDR_DIMS = ADDR_DIMS_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int ACC_BITS  = ACC_BITS_DEF,
  parameter int DEPTH     = DEPTH_DEF
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_start,
  input  logic                                 i_valid,
  output logic                                 o_ready,
  input  logic                                 i_last,
  input  logic [LANES*W_BITS-1:0]              i_w,
  input  logic [LANES*IA_BITS-1:0]             i_ia,
  input  logic [LANES*ADDR_DIMS*ADDR_BITS-1:0] i_addr,
  output logic                                 o_done,
  output logic [$clog2(DEPTH+1)-1:0]           o_count,
  output logic                                 o_overflow,
  input  logic                                 i_rd_en,
  input  logic [$clog2(DEPTH)-1:0]             i_rd_idx,
  output logic                                 o_rd_valid,
  output logic [ACC_BITS-1:0]                  o_rd_data
);

  localparam int AW    = ADDR_DIMS * ADDR_BITS;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SW    = W_BITS + IA_BITS + $clog2(LANES);
  localparam int TW    = ((SW > ACC_BITS) ? SW : ACC_BITS) + 1;
  localparam int RC_W  = $clog2(LANES + 1);
  localparam int PW    = CNT_W + RC_W + 1;
  localparam logic [TW-1:0] ACC_MAX = {{(TW-ACC_BITS){1'b0}}, {ACC_BITS{1'b1}}};

  state_e                 state_q, state_d;
  logic                   accept;
  logic                   first_q;
  logic [AW-1:0]          last_addr_q;
  logic [CNT_W-1:0]       ptr_q, ptr_d;
  logic                   ovf_q, ovf_d;
  logic                   drop_q, drop_d;
  logic [DEPTH-1:0]       valid_q, valid_d;
  logic [ACC_BITS-1:0]    buf_q [DEPTH];
  logic [ACC_BITS-1:0]    buf_d [DEPTH];
  logic                   rd_valid_q;
  logic [ACC_BITS-1:0]    rd_data_q;

  logic                   p2_valid, p2_last, p2_same0;
  logic [LANES-1:0][SW-1:0] p2_sum;
  logic [RC_W-1:0]        p2_cnt;

  logic [PW-1:0]          base, tgt, n_out, ptr_sum;
  logic [IDX_W-1:0]       idx;
  logic [TW-1:0]          sum_w;

  assign accept = i_valid && o_ready;

  psum_run_merger #(
    .LANES(LANES), .W_BITS(W_BITS), .IA_BITS(IA_BITS),
    .ADDR_DIMS(ADDR_DIMS), .ADDR_BITS(ADDR_BITS), .SUM_BITS(SW)
  ) u_merger (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .valid_i    (accept),
    .last_i     (i_last),
    .w_i        (i_w),
    .ia_i       (i_ia),
    .addr_i     (i_addr),
    .first_i    (first_q),
    .last_addr_i(last_addr_q),
    .valid_o    (p2_valid),
    .last_o     (p2_last),
    .run_sum_o  (p2_sum),
    .run_cnt_o  (p2_cnt),
    .same0_o    (p2_same0)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start) state_d = S_RUN;
      S_RUN:   if (accept && i_last) state_d = S_FLUSH;
      S_FLUSH: if (p2_valid && p2_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // P3: single-cycle read-modify-write, so a beat right behind another on the
  // same address sees the freshly written entry.
  always_comb begin
    buf_d   = buf_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    base    = PW'(ptr_q) - PW'(p2_same0);
    n_out   = PW'(p2_cnt) + PW'(p2_same0);
    ptr_sum = PW'(ptr_q) + PW'(p2_cnt);
    tgt     = '0;
    idx     = '0;
    sum_w   = '0;
    if (p2_valid) begin
      for (int r = 0; r < LANES; r++) begin
        tgt = base + PW'(r);
        idx = tgt[IDX_W-1:0];
        if (PW'(r) < n_out) begin
          // A merge into a run that was already dropped must be dropped too.
          if ((tgt >= PW'(DEPTH)) || ((r == 0) && p2_same0 && drop_q)) begin
            ovf_d  = 1'b1;
            drop_d = 1'b1;
          end else begin
            sum_w = (valid_q[idx] ? TW'(buf_q[idx]) : '0) + TW'(p2_sum[r]);
            if (sum_w > ACC_MAX) begin
              buf_d[idx] = '1;
              ovf_d      = 1'b1;
            end else begin
              buf_d[idx] = sum_w[ACC_BITS-1:0];
            end
            valid_d[idx] = 1'b1;
          end
        end
      end
      ptr_d = (ptr_sum > PW'(DEPTH)) ? CNT_W'(DEPTH) : ptr_sum[CNT_W-1:0];
    end
    if ((state_q == S_IDLE) && i_start) begin
      valid_d = '0;
      ptr_d   = '0;
      ovf_d   = 1'b0;
      drop_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      first_q     <= 1'b1;
      last_addr_q <= '0;
      ptr_q       <= '0;
      ovf_q       <= 1'b0;
      drop_q      <= 1'b0;
      valid_q     <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      if ((state_q == S_IDLE) && i_start) begin
        first_q <= 1'b1;
      end else if (accept) begin
        first_q     <= 1'b0;
        last_addr_q <= i_addr[(LANES-1)*AW +: AW];
      end
      rd_valid_q <= (state_q == S_IDLE) && i_rd_en;
      if ((state_q == S_IDLE) && i_rd_en) begin
        rd_data_q <= (({1'b0, i_rd_idx} < (IDX_W+1)'(DEPTH)) && valid_q[i_rd_idx]) ?
                     buf_q[i_rd_idx] : '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    buf_q <= buf_d;
  end

  assign o_ready    = (state_q == S_RUN);
  assign o_done     = (state_q == S_DONE);
  assign o_count    = ptr_q;
  assign o_overflow = ovf_q;
  assign o_rd_valid = rd_valid_q;
  assign o_rd_data  = rd_data_q;

endmodule

// File: tb/tb_sparse_psum_reducer.sv
// Directed bench for sparse_psum_reducer: default build plus DEPTH=4 and ACC_BITS=33 builds.
module tb_sparse_psum_reducer;

  logic        clk = 1'b0;
  logic        rst, start, valid, last, rd_en;
  logic [47:0] w, ia;
  logic [62:0] addr;
  logic [5:0]  rd_idx;

  logic        m_ready, m_done, m_ovf, m_rdv;
  logic [5:0]  m_count;
  logic [33:0] m_rdd;
  logic        d_ready, d_done, d_ovf, d_rdv;
  logic [2:0]  d_count;
  logic [33:0] d_rdd;
  logic        a_ready, a_done, a_ovf, a_rdv;
  logic [5:0]  a_count;
  logic [32:0] a_rdd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sparse_psum_reducer u_main (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid), .o_ready(m_ready),
    .i_last(last), .i_w(w), .i_ia(ia), .i_addr(addr), .o_done(m_done),
    .o_count(m_count), .o_overflow(m_ovf), .i_rd_en(rd_en), .i_rd_idx(rd_idx),
    .o_rd_valid(m_rdv), .o_rd_data(m_rdd)
  );

  sparse_psum_reducer #(.DEPTH(4)) u_d4 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid), .o_ready(d_ready),
    .i_last(last), .i_w(w), .i_ia(ia), .i_addr(addr), .o_done(d_done),
    .o_count(d_count), .o_overflow(d_ovf), .i_rd_en(rd_en), .i_rd_idx(rd_idx[1:0]),
    .o_rd_valid(d_rdv), .o_rd_data(d_rdd)
  );

  sparse_psum_reducer #(.ACC_BITS(33)) u_a33 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid), .o_ready(a_ready),
    .i_last(last), .i_w(w), .i_ia(ia), .i_addr(addr), .o_done(a_done),
    .o_count(a_count), .o_overflow(a_ovf), .i_rd_en(rd_en), .i_rd_idx(rd_idx),
    .o_rd_valid(a_rdv), .o_rd_data(a_rdd)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] l3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    return {c, b, a};
  endfunction

  function automatic logic [62:0] ad3(input logic [20:0] a, input logic [20:0] b, input logic [20:0] c);
    return {c, b, a};
  endfunction

  task automatic start_grp;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic beat(input logic [47:0] bw, input logic [47:0] bia, input logic [62:0] ba,
                      input logic bl);
    valid = 1'b1;
    w     = bw;
    ia    = bia;
    addr  = ba;
    last  = bl;
    tick;
    valid = 1'b0;
    last  = 1'b0;
  endtask

  // Called right after the last-beat acceptance edge; o_done is due two edges later.
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (m_done !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    check({tag, "_done_latency"}, 64'(n), 64'd2);
    check({tag, "_done_agree"}, {62'd0, d_done, a_done}, 64'd3);
  endtask

  task automatic rd(input logic [5:0] idx);
    rd_en  = 1'b1;
    rd_idx = idx;
    tick;
    rd_en  = 1'b0;
    check("rd_valid", 64'(m_rdv), 64'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; valid = 1'b0; last = 1'b0; rd_en = 1'b0;
    w = '0; ia = '0; addr = '0; rd_idx = '0;
    tick; tick;
    rst = 1'b0;

    check("rst_ready", {61'd0, m_ready, d_ready, a_ready}, 64'd0);
    check("rst_done", 64'(m_done), 64'd0);
    check("rst_count", 64'(m_count), 64'd0);
    check("rst_ovf", 64'(m_ovf), 64'd0);
    check("rst_rdv", 64'(m_rdv), 64'd0);
    check("rst_rdd", 64'(m_rdd), 64'd0);

    // distinct addresses, one beat
    start_grp;
    check("t1_ready_run", 64'(m_ready), 64'd1);
    beat(l3(2, 2, 2), l3(3, 3, 3), ad3(21'd1, 21'd2, 21'd3), 1'b1);
    check("t1_ready_drop", 64'(m_ready), 64'd0);
    wait_done("t1");
    check("t1_count", 64'(m_count), 64'd3);
    check("t1_ovf", 64'(m_ovf), 64'd0);
    tick;
    check("t1_done_pulse", 64'(m_done), 64'd0);
    rd(6'd0); check("t1_e0", 64'(m_rdd), 64'd6);
    rd(6'd1); check("t1_e1", 64'(m_rdd), 64'd6);
    rd(6'd2); check("t1_e2", 64'(m_rdd), 64'd6);
    rd(6'd3); check("t1_e3_unwritten", 64'(m_rdd), 64'd0);
    rd(6'd50); check("t1_idx_oob", 64'(m_rdd), 64'd0);
    tick;
    check("rd_valid_pulse", 64'(m_rdv), 64'd0);

    // all lanes equal address
    start_grp;
    beat(l3(1, 2, 3), l3(10, 10, 10), ad3(21'd5, 21'd5, 21'd5), 1'b1);
    wait_done("t2a");
    check("t2a_count", 64'(m_count), 64'd1);
    tick;
    rd(6'd0); check("t2a_e0", 64'(m_rdd), 64'd60);
    rd(6'd1); check("t2a_e1", 64'(m_rdd), 64'd0);

    // merge carried across the beat boundary
    start_grp;
    beat(l3(1, 2, 3), l3(10, 10, 10), ad3(21'd5, 21'd5, 21'd5), 1'b0);
    tick;
    beat(l3(1, 1, 1), l3(5, 5, 5), ad3(21'd5, 21'd5, 21'd5), 1'b1);
    wait_done("t2b");
    check("t2b_count", 64'(m_count), 64'd1);
    tick;
    rd(6'd0); check("t2b_e0", 64'(m_rdd), 64'd75);

    // four back-to-back beats on one address
    start_grp;
    beat(l3(1, 1, 1), l3(1, 1, 1), ad3(21'd9, 21'd9, 21'd9), 1'b0);
    beat(l3(1, 1, 1), l3(1, 1, 1), ad3(21'd9, 21'd9, 21'd9), 1'b0);
    beat(l3(1, 1, 1), l3(1, 1, 1), ad3(21'd9, 21'd9, 21'd9), 1'b0);
    beat(l3(1, 1, 1), l3(1, 1, 1), ad3(21'd9, 21'd9, 21'd9), 1'b1);
    wait_done("t3");
    check("t3_count", 64'(m_count), 64'd1);
    tick;
    rd(6'd0); check("t3_e0", 64'(m_rdd), 64'd12);
    rd(6'd1); check("t3_e1", 64'(m_rdd), 64'd0);

    // DEPTH=4 build drops two runs; default build keeps all six
    start_grp;
    beat(l3(1, 2, 3), l3(1, 1, 1), ad3(21'd1, 21'd2, 21'd3), 1'b0);
    beat(l3(4, 5, 6), l3(1, 1, 1), ad3(21'd4, 21'd5, 21'd6), 1'b1);
    wait_done("t4");
    check("t4_d4_count", 64'(d_count), 64'd4);
    check("t4_d4_ovf", 64'(d_ovf), 64'd1);
    check("t4_main_count", 64'(m_count), 64'd6);
    check("t4_main_ovf", 64'(m_ovf), 64'd0);
    tick;
    rd(6'd3);
    check("t4_d4_e3", 64'(d_rdd), 64'd4);
    check("t4_main_e3", 64'(m_rdd), 64'd4);
    rd(6'd0);
    check("t4_d4_e0", 64'(d_rdd), 64'd1);
    rd(6'd5);
    check("t4_main_e5", 64'(m_rdd), 64'd6);

    // saturation: 3*0xFFFE0001 per beat, two beats on one address
    start_grp;
    beat(l3(16'hFFFF, 16'hFFFF, 16'hFFFF), l3(16'hFFFF, 16'hFFFF, 16'hFFFF),
         ad3(21'd7, 21'd7, 21'd7), 1'b0);
    beat(l3(16'hFFFF, 16'hFFFF, 16'hFFFF), l3(16'hFFFF, 16'hFFFF, 16'hFFFF),
         ad3(21'd7, 21'd7, 21'd7), 1'b1);
    wait_done("t5");
    check("t5_a33_ovf", 64'(a_ovf), 64'd1);
    check("t5_a33_count", 64'(a_count), 64'd1);
    check("t5_main_ovf", 64'(m_ovf), 64'd1);
    tick;
    rd(6'd0);
    check("t5_a33_e0", 64'(a_rdd), 64'h1_FFFF_FFFF);
    check("t5_main_e0", 64'(m_rdd), 64'h3_FFFF_FFFF);

    // reset in the middle of a group
    start_grp;
    beat(l3(1, 1, 1), l3(1, 1, 1), ad3(21'd1, 21'd1, 21'd1), 1'b0);
    beat(l3(1, 1, 1), l3(1, 1, 1), ad3(21'd1, 21'd1, 21'd1), 1'b0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("t6_ready_after_rst", 64'(m_ready), 64'd0);
    check("t6_count_after_rst", 64'(m_count), 64'd0);
    check("t6_ovf_after_rst", 64'(m_ovf), 64'd0);
    tick; tick;
    rd(6'd0); check("t6_e0_after_rst", 64'(m_rdd), 64'd0);
    start_grp;
    rd_en = 1'b1; rd_idx = 6'd0;
    tick;
    rd_en = 1'b0;
    check("t6_rd_in_run", 64'(m_rdv), 64'd0);
    beat(l3(1, 1, 1), l3(2, 2, 2), ad3(21'd1, 21'd1, 21'd1), 1'b1);
    wait_done("t6");
    check("t6_count", 64'(m_count), 64'd1);
    tick;
    rd(6'd0); check("t6_e0", 64'(m_rdd), 64'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
